// File: rtl/bpu_table_access_ctrl.sv
// Access scheduler for a single-ported BPU prediction table.
// Grants the table port each cycle to a clear sweep, a buffered commit-time
// update, or a fetch-stage lookup. Lookups win over updates except when the
// oldest buffered update has waited STARVE_LIMIT cycles.
module bpu_table_access_ctrl #(
  parameter int                    ADDR_WIDTH   = 11,
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    FIFO_DEPTH   = 4,
  parameter int                    STARVE_LIMIT = 8,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             lookup_valid_i,
  input  logic [ADDR_WIDTH-1:0]            lookup_addr_i,
  output logic                             lookup_ready_o,
  output logic                             lookup_rvalid_o,
  input  logic                             upd_valid_i,
  input  logic [ADDR_WIDTH-1:0]            upd_addr_i,
  input  logic [DATA_WIDTH-1:0]            upd_data_i,
  output logic                             upd_ready_o,
  input  logic                             clear_req_i,
  output logic                             busy_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count_o,
  output logic                             tbl_en_o,
  output logic                             tbl_we_o,
  output logic [ADDR_WIDTH-1:0]            tbl_addr_o,
  output logic [DATA_WIDTH-1:0]            tbl_wdata_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } upd_t;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] clear_addr;
  upd_t                  fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic [SW-1:0]         starve_cnt;
  logic                  lookup_rvalid_q;

  logic run;
  logic fifo_empty;
  logic force_upd;
  logic lookup_grant;
  logic upd_grant;
  logic enq;
  logic flush;
  upd_t head;

  assign run          = (state == ST_RUN);
  assign fifo_empty   = (count == '0);
  assign head         = fifo_mem[rd_ptr];
  assign force_upd    = run && !fifo_empty && (starve_cnt == SW'(STARVE_LIMIT));
  assign lookup_grant = run && !force_upd && lookup_valid_i;
  assign upd_grant    = run && !fifo_empty && (force_upd || !lookup_valid_i);
  assign flush        = run && clear_req_i;

  // Slot availability uses the registered count, so a same-cycle dequeue
  // never opens a slot for an enqueue.
  assign upd_ready_o  = run && (count < CW'(FIFO_DEPTH));
  assign enq          = upd_valid_i && upd_ready_o;

  assign lookup_ready_o  = run && !force_upd;
  assign lookup_rvalid_o = lookup_rvalid_q;
  assign busy_o          = !run;
  assign fifo_count_o    = count;

  // Table port mux: clear sweep, then update write, then lookup read.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    tbl_en_o    = 1'b0;
    tbl_we_o    = 1'b0;
    tbl_addr_o  = lookup_addr_i;
    tbl_wdata_o = head.data;
    if (!run) begin
      tbl_en_o    = 1'b1;
      tbl_we_o    = 1'b1;
      tbl_addr_o  = clear_addr;
      tbl_wdata_o = CLEAR_VALUE;
    end else if (upd_grant) begin
      tbl_en_o   = 1'b1;
      tbl_we_o   = 1'b1;
      tbl_addr_o = head.addr;
    end else if (lookup_grant) begin
      tbl_en_o = 1'b1;
    end
  end

  // Sweep sequencing and CLEAR/RUN transitions; a clear request restarts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (!rst_n) begin
      state      <= ST_CLEAR;
      clear_addr <= '0;
    end else if (!run) begin
      if (clear_req_i) begin
        clear_addr <= '0;
      end else begin
        clear_addr <= clear_addr + ADDR_WIDTH'(1);
        if (clear_addr == '1) state <= ST_RUN;
      end
    end else if (clear_req_i) begin
      state      <= ST_CLEAR;
      clear_addr <= '0;
    end
  end

  // Update FIFO pointers and occupancy; flushed when a clear starts in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq)       wr_ptr <= wr_ptr + PW'(1);
      if (upd_grant) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, upd_grant})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are only observed through valid pointers.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; stale entries are never read
    // because occupancy is tracked by the reset pointers and count.
    if (enq) fifo_mem[wr_ptr] <= '{addr: upd_addr_i, data: upd_data_i};
  end

  // Count cycles the head update has been blocked by lookups.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!run || clear_req_i || upd_grant || fifo_empty) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Read data becomes valid at the RAM output one cycle after a granted lookup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lookup_rvalid_q <= 1'b0;
    else        lookup_rvalid_q <= lookup_grant;
  end

endmodule

// File: tb/tb_bpu_table_access_ctrl.sv
// Randomized bench for bpu_table_access_ctrl against a queue-based model of
// the table-port scheduling rules.
module tb_bpu_table_access_ctrl;

  localparam int          AW    = 3;
  localparam int          DW    = 8;
  localparam int          DEPTH = 4;
  localparam int          LIM   = 8;
  localparam logic [7:0]  CV    = 8'h5A;
  localparam int          NENT  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          lookup_valid_i;
  logic [AW-1:0] lookup_addr_i;
  logic          lookup_ready_o;
  logic          lookup_rvalid_o;
  logic          upd_valid_i;
  logic [AW-1:0] upd_addr_i;
  logic [DW-1:0] upd_data_i;
  logic          upd_ready_o;
  logic          clear_req_i;
  logic          busy_o;
  logic [2:0]    fifo_count_o;
  logic          tbl_en_o;
  logic          tbl_we_o;
  logic [AW-1:0] tbl_addr_o;
  logic [DW-1:0] tbl_wdata_o;

  bpu_table_access_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
    .STARVE_LIMIT(LIM), .CLEAR_VALUE(CV)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid_i(lookup_valid_i), .lookup_addr_i(lookup_addr_i),
    .lookup_ready_o(lookup_ready_o), .lookup_rvalid_o(lookup_rvalid_o),
    .upd_valid_i(upd_valid_i), .upd_addr_i(upd_addr_i), .upd_data_i(upd_data_i),
    .upd_ready_o(upd_ready_o), .clear_req_i(clear_req_i), .busy_o(busy_o),
    .fifo_count_o(fifo_count_o), .tbl_en_o(tbl_en_o), .tbl_we_o(tbl_we_o),
    .tbl_addr_o(tbl_addr_o), .tbl_wdata_o(tbl_wdata_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } upd_t;

  // Reference model state
  bit   m_clearing;
  int   m_sweep;
  int   m_starve;
  bit   m_rvalid;
  upd_t m_q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_clearing = 1'b1;
    m_sweep    = 0;
    m_starve   = 0;
    m_rvalid   = 1'b0;
    m_q.delete();
  endtask

  task automatic check_reset_vals();
    check("rst_busy",   32'(busy_o),          32'd1);
    check("rst_en",     32'(tbl_en_o),        32'd1);
    check("rst_we",     32'(tbl_we_o),        32'd1);
    check("rst_addr",   32'(tbl_addr_o),      32'd0);
    check("rst_wdata",  32'(tbl_wdata_o),     32'(CV));
    check("rst_lready", 32'(lookup_ready_o),  32'd0);
    check("rst_rvalid", 32'(lookup_rvalid_o), 32'd0);
    check("rst_uready", 32'(upd_ready_o),     32'd0);
    check("rst_count",  32'(fifo_count_o),    32'd0);
  endtask

  // Asserts reset immediately, checks the reset-state outputs, then releases
  // shortly after a later rising edge.
  task automatic reset_pulse();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_vals();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive random inputs, compare outputs against the model,
  // then advance the model at the rising edge.
  task automatic run_cycle(input int lv_pct, input int uv_pct, input int clr_pm);
    bit e_busy, e_lr, e_ur, e_en, e_we, forced, wrote, read, acc;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    int pre;
    @(negedge clk);
    lookup_valid_i = ($urandom_range(99) < lv_pct);
    lookup_addr_i  = AW'($urandom);
    upd_valid_i    = ($urandom_range(99) < uv_pct);
    upd_addr_i     = AW'($urandom);
    upd_data_i     = DW'($urandom);
    clear_req_i    = ($urandom_range(999) < clr_pm);
    #1;
    forced = 1'b0; wrote = 1'b0; read = 1'b0;
    e_addr = '0; e_data = '0;
    pre = m_q.size();
    if (m_clearing) begin
      e_busy = 1'b1; e_lr = 1'b0; e_ur = 1'b0;
      e_en = 1'b1; e_we = 1'b1; e_addr = AW'(m_sweep); e_data = CV;
    end else begin
      forced = (m_starve == LIM) && (pre > 0);
      e_busy = 1'b0;
      e_lr   = !forced;
      e_ur   = (pre < DEPTH);
      wrote  = (pre > 0) && (forced || !lookup_valid_i);
      read   = !forced && lookup_valid_i;
      e_en   = wrote || read;
      e_we   = wrote;
      if (wrote) begin
        e_addr = m_q[0].addr;
        e_data = m_q[0].data;
      end else begin
        e_addr = lookup_addr_i;
      end
    end
    check("busy",   32'(busy_o),          32'(e_busy));
    check("lready", 32'(lookup_ready_o),  32'(e_lr));
    check("uready", 32'(upd_ready_o),     32'(e_ur));
    check("count",  32'(fifo_count_o),    32'(pre));
    check("rvalid", 32'(lookup_rvalid_o), 32'(m_rvalid));
    check("tbl_en", 32'(tbl_en_o),        32'(e_en));
    if (e_en) begin
      check("tbl_we",   32'(tbl_we_o),   32'(e_we));
      check("tbl_addr", 32'(tbl_addr_o), 32'(e_addr));
    end
    if (e_we) check("tbl_wdata", 32'(tbl_wdata_o), 32'(e_data));

    @(posedge clk);
    m_rvalid = read;
    if (m_clearing) begin
      if (clear_req_i)           m_sweep = 0;
      else if (m_sweep == NENT-1) m_clearing = 1'b0;
      else                       m_sweep++;
    end else if (clear_req_i) begin
      m_clearing = 1'b1;
      m_sweep    = 0;
      m_starve   = 0;
      m_q.delete();
    end else begin
      acc = upd_valid_i && (pre < DEPTH);
      if (wrote) void'(m_q.pop_front());
      if (wrote || pre == 0) m_starve = 0;
      else if (m_starve < LIM) m_starve++;
      if (acc) m_q.push_back('{addr: upd_addr_i, data: upd_data_i});
    end
  endtask

  initial begin
    lookup_valid_i = 1'b0; lookup_addr_i = '0;
    upd_valid_i = 1'b0; upd_addr_i = '0; upd_data_i = '0;
    clear_req_i = 1'b0;
    reset_pulse();

    // Sweep up to address 5, then a clear request restarts it.
    repeat (5) run_cycle(50, 50, 0);
    run_cycle(50, 50, 1000);
    // Reset asserted at sweep address 5.
    repeat (5) run_cycle(50, 50, 0);
    @(negedge clk); #2;
    reset_pulse();

    // Full sweep then quiet RUN.
    repeat (NENT + 4) run_cycle(0, 0, 0);
    // Starvation: continuous lookups with sparse updates.
    repeat (300) run_cycle(100, 8, 0);
    // Backpressure: continuous lookups and updates.
    repeat (300) run_cycle(100, 100, 0);
    // Clear with a full buffer.
    run_cycle(100, 0, 1000);
    repeat (NENT + 2) run_cycle(30, 30, 0);
    // Mixed traffic.
    repeat (400) run_cycle(50, 50, 0);
    repeat (600) run_cycle(70, 60, 5);
    // Reset in RUN right after a granted lookup.
    repeat (NENT + 2) run_cycle(0, 0, 0);
    run_cycle(100, 0, 0);
    @(negedge clk); #2;
    reset_pulse();
    repeat (300) run_cycle(60, 40, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
